// File: rtl/ram_bus_arbiter.sv
// ram_bus_arbiter: two-master round-robin arbiter for the shared device bus.
// Optional tenure timeout is compiled in when ARB_TIMEOUT_EN is defined.
module ram_bus_arbiter #(
    parameter int unsigned TIMEOUT = 64
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        m0_req,
    input  logic        m1_req,
    output logic        m0_gnt,
    output logic        m1_gnt,
    input  logic [2:0]  m0_device_select,
    input  logic [2:0]  m1_device_select,
    input  logic [15:0] m0_addr,
    input  logic [15:0] m1_addr,
    input  logic        m0_we,
    input  logic        m1_we,
    input  logic        m0_oe,
    input  logic        m1_oe,
    input  logic [7:0]  m0_wdata,
    input  logic [7:0]  m1_wdata,
    output logic [7:0]  m0_rdata,
    output logic [7:0]  m1_rdata,
    output logic [2:0]  device_select,
    output logic [15:0] addr_out,
    output logic        we,
    output logic        oe,
    output logic [7:0]  wdata,
    input  logic [7:0]  rdata,
    output logic [1:0]  owner,
    output logic        arb_timeout
);

    localparam int unsigned CW = 8;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        GNT0 = 2'b01,
        GNT1 = 2'b10
    } state_e;

    state_e state_q, state_d;
    logic   last_owner_q, last_owner_d;
    logic   arb_timeout_q, arb_timeout_d;

`ifdef ARB_TIMEOUT_EN
    localparam logic [CW-1:0] TMAX = CW'(TIMEOUT - 1);
    logic [CW-1:0] tcnt_q, tcnt_d;
`else
    logic [CW-1:0] timeout_unused;
    assign timeout_unused = CW'(TIMEOUT);
`endif

    // Next-state, round-robin choice and tenure timeout
    always_comb begin
        state_d       = state_q;
        last_owner_d  = last_owner_q;
        arb_timeout_d = 1'b0;
`ifdef ARB_TIMEOUT_EN
        tcnt_d        = tcnt_q;
`endif
        case (state_q)
            IDLE: begin
                if (m0_req && (!m1_req || last_owner_q)) begin
                    state_d      = GNT0;
                    last_owner_d = 1'b0;
`ifdef ARB_TIMEOUT_EN
                    tcnt_d       = '0;
`endif
                end else if (m1_req) begin
                    state_d      = GNT1;
                    last_owner_d = 1'b1;
`ifdef ARB_TIMEOUT_EN
                    tcnt_d       = '0;
`endif
                end
            end
            GNT0: begin
                if (!m0_req) begin
                    state_d = IDLE;
                end
`ifdef ARB_TIMEOUT_EN
                else if (tcnt_q == TMAX) begin
                    if (m1_req) begin
                        state_d       = IDLE;
                        arb_timeout_d = 1'b1;
                    end
                end else begin
                    tcnt_d = tcnt_q + CW'(1);
                end
`endif
            end
            GNT1: begin
                if (!m1_req) begin
                    state_d = IDLE;
                end
`ifdef ARB_TIMEOUT_EN
                else if (tcnt_q == TMAX) begin
                    if (m0_req) begin
                        state_d       = IDLE;
                        arb_timeout_d = 1'b1;
                    end
                end else begin
                    tcnt_d = tcnt_q + CW'(1);
                end
`endif
            end
            default: state_d = IDLE;
        endcase
    end

    // State, last owner and timeout pulse registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            last_owner_q  <= 1'b1;
            arb_timeout_q <= 1'b0;
`ifdef ARB_TIMEOUT_EN
            tcnt_q        <= '0;
`endif
        end else begin
            state_q       <= state_d;
            last_owner_q  <= last_owner_d;
            arb_timeout_q <= arb_timeout_d;
`ifdef ARB_TIMEOUT_EN
            tcnt_q        <= tcnt_d;
`endif
        end
    end

    assign m0_gnt      = (state_q == GNT0);
    assign m1_gnt      = (state_q == GNT1);
    assign owner       = 2'(state_q);
    assign arb_timeout = arb_timeout_q;

    // Device-side bus mux and read return; idle bus selects nothing
    always_comb begin
        device_select = 3'b000;
        addr_out      = 16'h0000;
        we            = 1'b0;
        oe            = 1'b0;
        wdata         = 8'h00;
        m0_rdata      = 8'h00;
        m1_rdata      = 8'h00;
        case (state_q)
            GNT0: begin
                device_select = m0_device_select;
                addr_out      = m0_addr;
                we            = m0_we & m0_req;
                oe            = m0_oe & m0_req;
                wdata         = m0_wdata;
                if (m0_oe) m0_rdata = rdata;
            end
            GNT1: begin
                device_select = m1_device_select;
                addr_out      = m1_addr;
                we            = m1_we & m1_req;
                oe            = m1_oe & m1_req;
                wdata         = m1_wdata;
                if (m1_oe) m1_rdata = rdata;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_ram_bus_arbiter.sv
// Directed bench for ram_bus_arbiter with a small RAM model at select 3'b001.
module tb_ram_bus_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        m0_req, m1_req, m0_gnt, m1_gnt;
    logic [2:0]  m0_device_select, m1_device_select, device_select;
    logic [15:0] m0_addr, m1_addr, addr_out;
    logic        m0_we, m1_we, m0_oe, m1_oe, we, oe;
    logic [7:0]  m0_wdata, m1_wdata, m0_rdata, m1_rdata, wdata;
    wire  [7:0]  rdata;
    logic [1:0]  owner;
    logic        arb_timeout;

    int checks = 0;
    int errors = 0;
    int wr_count = 0;
    logic [7:0] ram [0:255] = '{default: 8'h00};

    always #5 clk = ~clk;

    ram_bus_arbiter #(.TIMEOUT(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .m0_req(m0_req), .m1_req(m1_req), .m0_gnt(m0_gnt), .m1_gnt(m1_gnt),
        .m0_device_select(m0_device_select), .m1_device_select(m1_device_select),
        .m0_addr(m0_addr), .m1_addr(m1_addr),
        .m0_we(m0_we), .m1_we(m1_we), .m0_oe(m0_oe), .m1_oe(m1_oe),
        .m0_wdata(m0_wdata), .m1_wdata(m1_wdata),
        .m0_rdata(m0_rdata), .m1_rdata(m1_rdata),
        .device_select(device_select), .addr_out(addr_out),
        .we(we), .oe(oe), .wdata(wdata), .rdata(rdata),
        .owner(owner), .arb_timeout(arb_timeout)
    );

    // RAM model: address 0x80 holds a fixed pattern, bus floats when not read
    assign rdata = (oe && device_select == 3'b001)
                   ? ((addr_out == 16'h0080) ? 8'h48 : ram[addr_out[7:0]]) : 8'hzz;

    always @(posedge clk) begin
        if (we && device_select == 3'b001) begin
            ram[addr_out[7:0]] <= wdata;
            wr_count <= wr_count + 1;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        m0_req = 0; m1_req = 0; m0_we = 0; m1_we = 0; m0_oe = 0; m1_oe = 0;
        m0_device_select = 3'b000; m1_device_select = 3'b000;
        m0_addr = 16'h0; m1_addr = 16'h0; m0_wdata = 8'h0; m1_wdata = 8'h0;
    endtask

    initial begin
        rst_n = 1'b0;
        clear_inputs();
        #12;
        // Reset values
        chk("rst_m0_gnt", 32'(m0_gnt), 0);
        chk("rst_m1_gnt", 32'(m1_gnt), 0);
        chk("rst_owner", 32'(owner), 0);
        chk("rst_timeout", 32'(arb_timeout), 0);
        chk("rst_we_oe", 32'({we, oe}), 0);
        chk("rst_dsel", 32'(device_select), 0);
        chk("rst_addr", 32'(addr_out), 0);
        chk("rst_wdata", 32'(wdata), 0);
        chk("rst_rdata", 32'({m0_rdata, m1_rdata}), 0);
        rst_n = 1'b1;

        // m0 write of 0xA5 to RAM address 0x0010
        step();
        m0_req = 1; m0_device_select = 3'b001; m0_addr = 16'h0010; m0_wdata = 8'hA5; m0_we = 1;
        #1;
        chk("w_gnt_before_edge", 32'(m0_gnt), 0);
        chk("w_we_idle", 32'(we), 0);
        step();
        chk("w_m0_gnt", 32'(m0_gnt), 1);
        chk("w_owner", 32'(owner), 32'h1);
        chk("w_bus", 32'({device_select, addr_out, wdata, we}), 32'({3'b001, 16'h0010, 8'hA5, 1'b1}));
        step();
        m0_we = 0; m0_req = 0;
        #1;
        chk("w_we_one_cycle", 32'(we), 0);
        step();
        chk("w_release_gnt", 32'(m0_gnt), 0);
        chk("w_release_owner", 32'(owner), 0);
        chk("w_ram16", 32'(ram[16]), 32'hA5);

        // m0 reads back, then reads 0x80; m1 attempts a write meanwhile
        m0_req = 1; m0_oe = 1; m0_addr = 16'h0010;
        step();
        chk("r_readback", 32'(m0_rdata), 32'hA5);
        m0_addr = 16'h0080;
        #1;
        chk("r_m0_rdata", 32'(m0_rdata), 32'h48);
        chk("r_m1_rdata", 32'(m1_rdata), 0);
        m1_req = 1; m1_we = 1; m1_oe = 1; m1_device_select = 3'b001;
        m1_addr = 16'h0020; m1_wdata = 8'h3C;
        m0_oe = 0; m0_we = 1; m0_addr = 16'h0030; m0_wdata = 8'h77;
        #1;
        chk("nw_we_m0", 32'(we), 1);
        chk("nw_wdata_m0", 32'({addr_out, wdata}), 32'({16'h0030, 8'h77}));
        chk("nw_m1_rdata", 32'(m1_rdata), 0);
        step();
        m0_we = 0; m0_req = 0;
        #1;
        chk("nw_we_follows_m0", 32'(we), 0);
        chk("nw_wdata_not_m1", 32'(wdata), 32'h77);
        step();
        chk("ho_idle_gnt", 32'({m0_gnt, m1_gnt}), 0);
        chk("ho_idle_bus", 32'({device_select, we, oe, wdata}), 0);
        step();
        chk("ho_m1_gnt", 32'(m1_gnt), 1);
        chk("ho_owner", 32'(owner), 32'h2);
        chk("ho_m1_bus", 32'({we, oe, wdata}), 32'({1'b1, 1'b1, 8'h3C}));

        // Asynchronous reset in the middle of m1's write
        #1;
        rst_n = 1'b0;
        #1;
        chk("ar_m1_gnt", 32'(m1_gnt), 0);
        chk("ar_we_oe", 32'({we, oe}), 0);
        chk("ar_owner", 32'(owner), 0);
        clear_inputs();
        step();
        chk("ar_no_write", 32'(ram[8'h20]), 0);
        rst_n = 1'b1;

        // Tie handling and round robin
        m0_req = 1; m1_req = 1;
        step();
        chk("tie1_m0", 32'({m0_gnt, m1_gnt}), 32'h2);
        m0_req = 0;
        step();
        chk("tie1_turnaround", 32'({m0_gnt, m1_gnt}), 0);
        step();
        chk("tie1_then_m1", 32'({m0_gnt, m1_gnt}), 32'h1);
        m1_req = 0;
        step();
        m0_req = 1; m1_req = 1;
        step();
        chk("tie2_m0", 32'({m0_gnt, m1_gnt}), 32'h2);
        m0_req = 0; m1_req = 0;
        step();
        m0_req = 1; m1_req = 1;
        step();
        chk("tie3_m1_first", 32'({m0_gnt, m1_gnt}), 32'h1);
        m0_req = 0; m1_req = 0;
        step();
        step();

        // m0 holds while m1 requests (last owner m1, so m0 wins the tie)
        m0_req = 1; m1_req = 1;
`ifdef ARB_TIMEOUT_EN
        for (int i = 0; i < 4; i++) begin
            step();
            chk("to_m0_held", 32'({m0_gnt, arb_timeout}), 32'h2);
        end
        step();
        chk("to_revoked", 32'({m0_gnt, m1_gnt, arb_timeout}), 32'h1);
        step();
        chk("to_m1_granted", 32'({m0_gnt, m1_gnt, arb_timeout}), 32'h2);
`else
        for (int i = 0; i < 10; i++) begin
            step();
            chk("nto_m0_held", 32'({m0_gnt, m1_gnt, arb_timeout}), 32'h4);
        end
`endif
        clear_inputs();
        step();
        chk("write_count", 32'(wr_count), 2);
        chk("ram30", 32'(ram[8'h30]), 32'h77);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/ram_bus_arbiter.md
# ram_bus_arbiter

Two-master arbiter that shares the single device bus (device select, 16-bit address, we/oe, 8-bit data) between the CPU core and a secondary master such as a DMA or boot loader. It sits between the masters and the memory-mapped devices (RAM at select 3'b001, UART, and so on). It grants ownership with a registered req/gnt handshake and round-robin fairness. It forces the bus to an idle, non-selecting state whenever no master owns it.

## Interface
- `TIMEOUT`, default 64: maximum cycles one master may hold the bus while the other is requesting. Used only with `ARB_TIMEOUT_EN`. Legal range 2..255.
- `clk` in 1: system clock. All state changes on the rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `m0_req`, `m1_req` in 1 each: bus request. Held high for the whole tenure.
- `m0_gnt`, `m1_gnt` out 1 each: registered grant. The two are never high together.
- `m0_device_select`, `m1_device_select` in 3 each: target device of each master.
- `m0_addr`, `m1_addr` in 16 each: address of each master.
- `m0_we`, `m1_we`, `m0_oe`, `m1_oe` in 1 each: write and output enables of each master.
- `m0_wdata`, `m1_wdata` in 8 each: write data of each master.
- `m0_rdata`, `m1_rdata` out 8 each: read data returned to each master.
- `device_select` out 3: to devices. 3'b000 selects no device.
- `addr_out` out 16, `we` out 1, `oe` out 1, `wdata` out 8: to devices.
- `rdata` in 8: shared device read bus. May be Z when no device drives it.
- `owner` out 2: 2'b00 none, 2'b01 m0, 2'b10 m1.
- `arb_timeout` out 1: one-cycle pulse when a grant is revoked by timeout.

## Operation
- FSM states: IDLE, GNT0, GNT1. Reset state is IDLE.
- Transitions from IDLE:
  - Only one request high: go to that master's GNTx.
  - Both requests high: grant the master that is not `last_owner`.
  - No request: stay in IDLE.
- `last_owner` is a 1-bit register. Reset value is 1, so m0 wins the first tie. It updates on every entry into GNTx.
- In GNTx, the state holds while `mx_req` is high.
- In GNTx, when `mx_req` is sampled low, the next state is IDLE. IDLE always lasts at least one cycle; this is the bus turnaround cycle. There is no direct GNT0 to GNT1 transition.
- `mx_gnt` is high exactly when the state is GNTx. Both grants are decoded from registered state.
- Bus mux (combinational from the state):
  - GNTx: the device-side outputs follow master x's inputs, but `we` and `oe` are each ANDed with `mx_req`.
  - IDLE: `device_select`=3'b000, `addr_out`=16'h0000, `we`=0, `oe`=0, `wdata`=8'h00.
- Read return: `mx_rdata` = `rdata` when the state is GNTx and `mx_oe` is high; otherwise 8'h00. A non-owner never sees another master's data and never sees Z.
- Writes from a master without a grant are dropped. No buffering.
- Reset mid-tenure: all grants drop asynchronously, the bus goes idle immediately, and an in-flight write is not issued.

## Timing
- Reset values: `m0_gnt`=0, `m1_gnt`=0, `owner`=2'b00, `arb_timeout`=0, `we`=0, `oe`=0, `device_select`=3'b000, `addr_out`=16'h0000, `wdata`=8'h00, `m0_rdata`=8'h00, `m1_rdata`=8'h00.
- Grant latency: a request sampled at edge k from IDLE gives `gnt` high after edge k.
- Handoff: `m0_req` sampled low at edge j leaves GNT0 at j. IDLE runs for cycle j..j+1. `m1_gnt` rises after edge j+1. Minimum gap between tenures is 1 cycle.
- A device write occurs at the first rising edge where `we` is high with a grant. A read is combinational within the granted cycle.

## Configuration
- `ARB_TIMEOUT_EN` defined:
  - An 8-bit tenure counter clears on entry into GNTx and increments each cycle in GNTx.
  - The timeout fires when the counter equals `TIMEOUT`-1 while the other master is requesting. The next state is then IDLE and `last_owner`=x, so the other master wins the tie.
  - `arb_timeout` pulses high for one cycle, in the cycle the state is IDLE after the revocation.
  - The counter saturates at `TIMEOUT`-1 if the other master is not requesting.
- `ARB_TIMEOUT_EN` undefined: there is no counter, tenure is unbounded, and `arb_timeout` is tied to 0.

## Test plan
- Reset, then m0 requests, writes 8'hA5 to select 3'b001 address 16'h0010, then releases. Required: `m0_gnt` high one cycle after the request; device `we` high for exactly one cycle; RAM[16] reads back 8'hA5.
- m0 and m1 request in the same cycle after reset. Required: m0 granted first. After m0 releases, one IDLE cycle, then `m1_gnt`. Repeating the tie grants m1 first.
- m1 drives `m1_we`=1 while m0 owns the bus. Required: device `we` follows m0 only; m1's data never reaches `wdata`; `m1_rdata`=8'h00.
- m0 reads RAM address 16'h0080 with `rdata`=8'h48. Required: `m0_rdata`=8'h48 in the same cycle; `m1_rdata`=8'h00.
- `rst_n` asserted mid-write while m1 is granted. Required: `m1_gnt`, `we` and `oe` go low immediately without waiting for an edge; `owner`=2'b00.
- With `ARB_TIMEOUT_EN` and `TIMEOUT`=4: m0 holds its request and m1 requests. Required: m0 is revoked after 4 granted cycles; `arb_timeout` pulses once; m1 is granted next.
